// File: rtl/mem_pkg.sv
// Shared types and default geometry for the cache-line memory responder.
package mem_pkg;

  // Responder sequencing: accept, fixed wait, one word-serial burst, completion pulse.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    DONE
  } mem_state_t;

  // Direction of the line transfer latched at acceptance.
  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_t;

  // Default geometry: 32-bit words, 8-word (32-byte) lines, 4096-word array.
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_LATENCY        = 4;
  localparam int DEF_MEM_WORDS      = 4096;

  // Beat index width and byte-offset width within a line for the default geometry.
  localparam int BEAT_W   = $clog2(DEF_WORDS_PER_LINE);
  localparam int OFFSET_W = $clog2(DEF_WORDS_PER_LINE * DEF_DATA_W / 8);

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with registered read (read-before-write).
module mem_word_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write plus registered read; contents are intentionally never reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cache_line_mem_responder.sv
// Memory-side responder: one line request, fixed access latency, then a
// word-serial fill (read) or writeback (write) burst and a done pulse.
module cache_line_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int LATENCY        = DEF_LATENCY,
  parameter int MEM_WORDS      = DEF_MEM_WORDS
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              req_rd,
  input  logic                              req_wr,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic                              wr_valid,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic                              busy,
  output logic                              wr_ready,
  output logic                              rd_valid,
  output logic [DATA_W-1:0]                 rd_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] beat_idx,
  output logic                              done
);

  localparam int BW      = $clog2(WORDS_PER_LINE);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int MEM_AW  = $clog2(MEM_WORDS);
  localparam int LINE_W  = MEM_AW - BW;
  localparam int LAT_W   = $clog2(LATENCY + 1);
  localparam int LINE_LO = BYTE_SH + BW;
  localparam int LINE_HI = BYTE_SH + MEM_AW;

  localparam logic [BW-1:0]    LAST_BEAT = BW'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(LATENCY - 1);

  mem_state_t          state_q, state_d;
  mem_op_t             op_q, op_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                busy_q, wr_ready_q, rd_valid_q, done_q;

  logic [LINE_W-1:0]   req_line;
  logic [BW-1:0]       beat_inc;
  logic                ram_we;
  logic [MEM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_rdata;
  logic                unused_addr_bits;

  // Line index inside the array: word index modulo MEM_WORDS with the beat offset dropped,
  // so out-of-range addresses wrap and a line can never straddle the array end.
  assign req_line         = req_addr[LINE_HI-1:LINE_LO];
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:LINE_HI], req_addr[LINE_LO-1:0]};
  assign beat_inc         = beat_q + BW'(1);

  // Next-state, counters and RAM port control; the RAM read is issued one cycle ahead of each beat.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    line_d   = line_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    ram_we   = 1'b0;
    ram_addr = {line_q, beat_q};
    case (state_q)
      IDLE: begin
        if (req_wr) begin
          op_d    = OP_WR;
          line_d  = req_line;
          lat_d   = '0;
          state_d = WAIT;
        end else if (req_rd) begin
          op_d    = OP_RD;
          line_d  = req_line;
          lat_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        ram_addr = {line_q, {BW{1'b0}}};
        if (lat_q == LAST_LAT) begin
          beat_d  = '0;
          state_d = (op_q == OP_WR) ? WR_BURST : RD_BURST;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      RD_BURST: begin
        ram_addr = {line_q, beat_inc};
        beat_d   = beat_inc;
        if (beat_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      WR_BURST: begin
        if (wr_valid) begin
          ram_we = ~RST;
          beat_d = beat_inc;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Responder state and registered status outputs decoded from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      line_q     <= '0;
      lat_q      <= '0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      line_q     <= line_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      busy_q     <= (state_d != IDLE);
      wr_ready_q <= (state_d == WR_BURST);
      rd_valid_q <= (state_d == RD_BURST);
      done_q     <= (state_d == DONE);
    end
  end

  mem_word_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_WORDS)
  ) u_mem (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  assign busy     = busy_q;
  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign done     = done_q;
  assign beat_idx = beat_q;
  // Fill data is only driven while a beat is valid, so it reads 0 after reset and between bursts.
  assign rd_data  = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_cache_line_mem_responder.sv
// Self-checking bench for cache_line_mem_responder against a word-array scoreboard.
module tb_cache_line_mem_responder;

  localparam int LATENCY = 4;
  localparam int WPL     = 8;
  localparam int MEMW    = 4096;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, wr_ready, rd_valid, done;
  logic [31:0] rd_data;
  logic [2:0]  beat_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [MEMW];
  logic [31:0] beat_buf  [WPL];

  cache_line_mem_responder #(
    .DATA_W(32), .ADDR_W(32), .WORDS_PER_LINE(WPL), .LATENCY(LATENCY), .MEM_WORDS(MEMW)
  ) dut (
    .CLK(CLK), .RST(RST), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_data(wr_data), .busy(busy), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .beat_idx(beat_idx), .done(done)
  );

  always #5 CLK = ~CLK;

  // First word of the line holding byte address a: word index modulo array depth, line aligned.
  function automatic int line_base(input logic [31:0] a);
    int w;
    w = int'((a >> 2) % MEMW);
    return w - (w % WPL);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 ||
        beat_idx !== 3'd0 || done !== 1'b0)
    begin
      n_fail++;
      $display("FAIL %s: busy=%b wr_ready=%b rd_valid=%b rd_data=%h beat_idx=%0d done=%b, required all zero",
               name, busy, wr_ready, rd_valid, rd_data, beat_idx, done);
    end
  endtask

  // Writeback of beat_buf to the line at addr; stall[k] inserts an idle cycle before beat k.
  // abort_at>=0 resets the responder before beat abort_at is written.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] stall, input bit with_rd,
                          input bit poke_rd, input int abort_at, input string name);
    int base;
    base = line_base(addr);
    req_wr = 1'b1; req_rd = with_rd; req_addr = addr;
    tick();
    req_wr = 1'b0; req_rd = 1'b0;
    for (int c = 0; c < LATENCY; c++) begin
      n_checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait cycle %0d: busy=%b wr_ready=%b rd_valid=%b done=%b, required 1 0 0 0",
                 name, c, busy, wr_ready, rd_valid, done);
      end
      tick();
    end
    for (int k = 0; k < WPL; k++) begin
      if (stall[k]) begin
        wr_valid = 1'b0;
        n_checks++;
        if (wr_ready !== 1'b1 || done !== 1'b0 || beat_idx !== 3'(k)) begin
          n_fail++;
          $display("FAIL %s stall before beat %0d: wr_ready=%b done=%b beat_idx=%0d, required 1 0 %0d",
                   name, k, wr_ready, done, beat_idx, k);
        end
        tick();
      end
      if (abort_at == k) begin
        wr_valid = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        check_idle({name, " reset"});
        $display("write %s addr=%h reset after %0d beats", name, addr, k);
        return;
      end
      n_checks++;
      if (wr_ready !== 1'b1 || beat_idx !== 3'(k)) begin
        n_fail++;
        $display("FAIL %s beat %0d: wr_ready=%b beat_idx=%0d, required 1 %0d", name, k, wr_ready, beat_idx, k);
      end
      wr_valid = 1'b1; wr_data = beat_buf[k];
      if (poke_rd && k == 2) begin
        req_rd = 1'b1; req_addr = addr ^ 32'h0000_4000;
      end
      tick();
      wr_valid = 1'b0; req_rd = 1'b0;
      model_mem[base + k] = beat_buf[k];
    end
    n_checks++;
    if (done !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: done=%b wr_ready=%b busy=%b, required 1 0 1", name, done, wr_ready, busy);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after done cycle %0d: busy=%b done=%b rd_valid=%b wr_ready=%b, required all 0",
                 name, c, busy, done, rd_valid, wr_ready);
      end
      tick();
    end
    $display("write %s addr=%h base=%h stall=%b", name, addr, base, stall);
  endtask

  // Line fill from addr checked against the scoreboard; abort_at>=0 resets on that beat.
  task automatic do_read(input logic [31:0] addr, input int abort_at, input string name);
    int base;
    base = line_base(addr);
    req_rd = 1'b1; req_addr = addr;
    tick();
    req_rd = 1'b0;
    for (int c = 0; c < LATENCY; c++) begin
      n_checks++;
      if (busy !== 1'b1 || rd_valid !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s wait cycle %0d: busy=%b rd_valid=%b wr_ready=%b done=%b, required 1 0 0 0",
                 name, c, busy, rd_valid, wr_ready, done);
      end
      tick();
    end
    for (int k = 0; k < WPL; k++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || beat_idx !== 3'(k) || rd_data !== model_mem[base + k] || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat %0d: rd_valid=%b beat_idx=%0d rd_data=%h done=%b, required 1 %0d %h 0",
                 name, k, rd_valid, beat_idx, rd_data, done, k, model_mem[base + k]);
      end
      if (abort_at == k) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_idle({name, " reset"});
        $display("read %s addr=%h reset on beat %0d", name, addr, k);
        return;
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done: done=%b rd_valid=%b busy=%b, required 1 0 1", name, done, rd_valid, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after done: done=%b busy=%b, required 0 0", name, done, busy);
    end
    $display("read %s addr=%h base=%h", name, addr, base);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    check_idle("reset");
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle("idle no request");
    end
    $display("reset done");
  endtask

  task automatic test_fill();
    for (int k = 0; k < WPL; k++) beat_buf[k] = 32'hA0 + 32'(k);
    do_write(32'h100, 8'b0, 1'b0, 1'b0, -1, "preload");
    do_read(32'h100, -1, "fill");
  endtask

  task automatic test_writeback_stalls();
    for (int k = 0; k < WPL; k++) beat_buf[k] = 32'h11 + 32'(k);
    do_write(32'h200, 8'b0100_1000, 1'b0, 1'b0, -1, "wb_stall");
    do_read(32'h200, -1, "wb_readback");
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < WPL; k++) beat_buf[k] = 32'hC0DE_0000 + 32'(k);
    do_write(32'h340, 8'b0, 1'b1, 1'b0, -1, "both_req");
    do_read(32'h340, -1, "both_readback");
  endtask

  task automatic test_busy_ignore();
    for (int k = 0; k < WPL; k++) beat_buf[k] = 32'hBEEF_0000 + 32'(k);
    do_write(32'h400, 8'b0000_0010, 1'b0, 1'b1, -1, "busy_ignore");
  endtask

  task automatic test_reset_mid_burst();
    do_read(32'h100, 3, "rd_abort");
    do_read(32'h100, -1, "rd_after_abort");
    for (int k = 0; k < WPL; k++) beat_buf[k] = 32'h5500_0000 + 32'(k);
    do_write(32'h200, 8'b0, 1'b0, 1'b0, 3, "wr_abort");
    do_read(32'h200, -1, "wr_abort_readback");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  st;
    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      st = 8'($urandom_range(0, 255));
      for (int k = 0; k < WPL; k++) beat_buf[k] = $urandom;
      do_write(a, st, 1'b0, 1'b0, -1, "rand_wr");
      do_read(a, -1, "rand_rd");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_writeback_stalls();
    test_simultaneous();
    test_busy_ignore();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
